// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the 6-digit display.
// The display register changes exactly once per accepted request, on the done cycle.
module bin2bcd_seq #(
    parameter int BIN_W   = 20,
    parameter int DIGITS  = 6,
    parameter int MAX_VAL = 999999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [4*DIGITS-1:0]   valor,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W:0]   MAX_V    = MAX_VAL[BIN_W:0];

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   bin_reg;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pending;
    logic               load;
    logic               step;
    logic               finish;

    // Per-digit add-3 correction; digits never carry into their neighbours.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (s[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = s[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control path: FSM, counter, flags and the display holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            valor       <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= finish;
            if (load) begin
                cnt         <= '0;
                ovf_pending <= ({1'b0, bin} > MAX_V);
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (finish) begin
                valor <= ovf_pending ? '1 : scratch;
                ovf   <= ovf_pending;
            end
        end
    end

    // Datapath: scratch and binary shift register, no reset needed.
    always_ff @(posedge clk) begin
        if (load) begin
            bin_reg <= bin;
            scratch <= '0;
        end else if (step) begin
            {scratch, bin_reg} <= {add3_digits(scratch), bin_reg} << 1;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus a random scoreboard
// against an arithmetic decimal-digit reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] bin = '0;
    logic [23:0] valor;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6), .MAX_VAL(999999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .valor (valor),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    function automatic logic [23:0] ref_bcd(input int v);
        logic [23:0] r;
        int x;
        if (v > 999999) return 24'hFFFFFF;
        r = '0;
        x = v;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Issues one request from IDLE; lat = edges from accept edge to done, bsy = busy samples.
    task automatic convert(input logic [19:0] v, output int lat, output int bsy, output bit seen);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bsy  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bsy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({valor, busy, done, ovf} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valor=%h busy=%b done=%b ovf=%b, need all zero", valor, busy, done, ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int lat, bsy; bit seen;
        convert(20'd0, lat, bsy, seen);
        n_checks++;
        if (!seen || lat != 21) begin
            n_fail++;
            $display("FAIL zero_latency: got seen=%b lat=%0d, need lat=21", seen, lat);
        end
        n_checks++;
        if (bsy != 21) begin
            n_fail++;
            $display("FAIL zero_busy_cycles: got %0d, need 21", bsy);
        end
        n_checks++;
        if (valor !== 24'h000000 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_value: got valor=%h ovf=%b, need 000000 ovf=0", valor, ovf);
        end
    endtask

    task automatic test_basic();
        int lat, bsy; bit seen;
        convert(20'd123456, lat, bsy, seen);
        n_checks++;
        if (!seen || lat != 21 || valor !== 24'h123456 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_123456: got seen=%b lat=%0d valor=%h ovf=%b, need lat=21 valor=123456 ovf=0",
                     seen, lat, valor, ovf);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b busy=%b after pulse, need 0 0", done, busy);
        end
    endtask

    task automatic test_overflow();
        int lat, bsy; bit seen;
        logic [19:0] vals [3];
        logic [23:0] expv [3];
        logic        expo [3];
        vals[0] = 20'd999999;  expv[0] = 24'h999999; expo[0] = 1'b0;
        vals[1] = 20'd1000000; expv[1] = 24'hFFFFFF; expo[1] = 1'b1;
        vals[2] = 20'd42;      expv[2] = 24'h000042; expo[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            convert(vals[i], lat, bsy, seen);
            n_checks++;
            if (!seen || lat != 21 || valor !== expv[i] || ovf !== expo[i]) begin
                n_fail++;
                $display("FAIL overflow_seq[%0d]: got seen=%b lat=%0d valor=%h ovf=%b, need lat=21 valor=%h ovf=%b",
                         i, seen, lat, valor, ovf, expv[i], expo[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int dones;
        logic [23:0] last;
        @(negedge clk);
        start = 1'b1;
        bin   = 20'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 20'd777;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        last  = 24'h0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin
                dones++;
                last = valor;
            end
            @(negedge clk);
        end
        n_checks++;
        if (dones != 1 || last !== 24'h000500 || valor !== 24'h000500) begin
            n_fail++;
            $display("FAIL busy_ignore: got dones=%0d valor=%h, need 1 done valor=000500", dones, valor);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bsy, dones; bit seen;
        @(negedge clk);
        start = 1'b1;
        bin   = 20'd65535;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valor !== 24'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got valor=%h busy=%b done=%b, need 000000 0 0", valor, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones != 0 || valor !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d busy/done samples valor=%h, need 0 and 000000", dones, valor);
        end
        convert(20'd65535, lat, bsy, seen);
        n_checks++;
        if (!seen || lat != 21 || valor !== 24'h065535) begin
            n_fail++;
            $display("FAIL after_reset: got seen=%b lat=%0d valor=%h, need lat=21 valor=065535", seen, lat, valor);
        end
    endtask

    task automatic test_back_to_back();
        int prev_cycle;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        bin   = 20'd1;
        prev_cycle = 0;
        for (int j = 1; j <= 4; j++) begin
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!seen || valor !== ref_bcd(j)) begin
                n_fail++;
                $display("FAIL b2b_value[%0d]: got seen=%b valor=%h, need %h", j, seen, valor, ref_bcd(j));
            end
            if (j > 1) begin
                n_checks++;
                if (cycle - prev_cycle != 22) begin
                    n_fail++;
                    $display("FAIL b2b_period[%0d]: got %0d cycles, need 22", j, cycle - prev_cycle);
                end
            end
            prev_cycle = cycle;
            bin = 20'(j + 1);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
    endtask

    task automatic test_random();
        int lat, bsy; bit seen;
        logic [19:0] v;
        logic [23:0] expv;
        for (int n = 0; n < 1000; n++) begin
            v = 20'($urandom_range(0, 20'hFFFFF));
            expv = ref_bcd(int'(v));
            convert(v, lat, bsy, seen);
            n_checks++;
            if (!seen || lat != 21 || valor !== expv || ovf !== (int'(v) > 999999)) begin
                n_fail++;
                $display("FAIL random[%0d] bin=%0d: got seen=%b lat=%0d valor=%h ovf=%b, need lat=21 valor=%h ovf=%b",
                         n, v, seen, lat, valor, ovf, expv, (int'(v) > 999999));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_basic();
        test_overflow();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
